// File: rtl/updown_counter_bank.sv
// -----------------------------------------------------------------------------
// updown_counter_bank
//
// Purpose:
//   A bank of CHANNELS independent WIDTH-bit up/down counters. All counters
//   share one prescaled step tick. Each channel has its own load, enable and
//   direction inputs, and an event flag. The event flag reports a wrap, or a
//   clamp when saturation is enabled. This block replaces the old single
//   16-bit mouse-driven counter. It sits between input-sampling logic and
//   display or register consumers.
//
// Configuration macro:
//   UPDOWN_COUNTER_BANK_SATURATE_EN
//     undefined : wrap mode. Results are taken modulo 2**WIDTH. event_flag
//                 pulses after a step that crosses max->0 or 0->max.
//     defined   : saturate mode. A step that would cross the boundary clamps
//                 to max (up) or 0 (down). event_flag pulses after every
//                 clamped step, including steps issued while already at the
//                 limit.
//
// Ports:
//   clock       in   1               single clock, posedge active
//   reset_      in   1               asynchronous active-low reset
//   en          in   CHANNELS        per-channel count enable (sampled on tick)
//   up          in   CHANNELS        per-channel direction, 1 = +STEP
//   load        in   CHANNELS        per-channel synchronous load (wins over step)
//   load_value  in   CHANNELS*WIDTH  load data, channel i at [i*WIDTH +: WIDTH]
//   value       out  CHANNELS*WIDTH  registered counter values, same packing
//   event_flag  out  CHANNELS        registered 1-cycle wrap/clamp pulse
//   tick        out  1               high in the cycle whose closing edge steps
//   half_clock  out  1               registered, toggles on every tick
// -----------------------------------------------------------------------------
module updown_counter_bank #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 16,
  parameter int DIV_LOG2    = 1,
  parameter int STEP        = 1,
  parameter int RESET_VALUE = 0
) (
  input  logic                      clock,
  input  logic                      reset_,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       up,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] load_value,
  output logic [CHANNELS*WIDTH-1:0] value,
  output logic [CHANNELS-1:0]       event_flag,
  output logic                      tick,
  output logic                      half_clock
);

  // One extra bit holds the carry or borrow of each step.
  localparam logic [WIDTH:0]   STEP_EXT  = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] RST_VAL   = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_VAL   = {WIDTH{1'b0}};

  logic tick_s;
  logic half_clock_r;

  generate
    if (DIV_LOG2 == 0) begin : g_no_div
      assign tick_s = 1'b1;
    end else begin : g_div
      logic [DIV_LOG2-1:0] presc_r;

      // Free-running prescaler; the tick fires when it holds all ones.
      always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
          presc_r <= {DIV_LOG2{1'b0}};
        end else begin
          presc_r <= presc_r + DIV_LOG2'(1);
        end
      end

      assign tick_s = &presc_r;
    end
  endgenerate

  // half_clock flips on every tick, whether or not any channel is enabled.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      half_clock_r <= 1'b0;
    end else if (tick_s) begin
      half_clock_r <= ~half_clock_r;
    end else begin
      half_clock_r <= half_clock_r;
    end
  end

  assign tick       = tick_s;
  assign half_clock = half_clock_r;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [WIDTH-1:0] cnt_r;
      logic             flag_r;
      logic [WIDTH-1:0] cnt_nxt_s;
      logic             flag_nxt_s;
      logic [WIDTH:0]   sum_s;
      logic             cross_s;

      // A set top bit in the WIDTH+1 result means the step crossed the boundary.
      assign sum_s   = up[gi] ? ({1'b0, cnt_r} + STEP_EXT)
                              : ({1'b0, cnt_r} - STEP_EXT);
      assign cross_s = sum_s[WIDTH];

      // Next-state select: load beats step, step beats hold.
      always_comb begin
        cnt_nxt_s  = cnt_r;
        flag_nxt_s = 1'b0;
        if (load[gi]) begin
          cnt_nxt_s  = load_value[gi*WIDTH +: WIDTH];
          flag_nxt_s = 1'b0;
        end else if (tick_s && en[gi]) begin
`ifdef UPDOWN_COUNTER_BANK_SATURATE_EN
          if (cross_s) begin
            cnt_nxt_s = up[gi] ? MAX_VAL : MIN_VAL;
          end else begin
            cnt_nxt_s = sum_s[WIDTH-1:0];
          end
`else
          cnt_nxt_s = sum_s[WIDTH-1:0];
`endif
          flag_nxt_s = cross_s;
        end else begin
          cnt_nxt_s  = cnt_r;
          flag_nxt_s = 1'b0;
        end
      end

      // Per-channel counter and event flag registers.
      always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
          cnt_r  <= RST_VAL;
          flag_r <= 1'b0;
        end else begin
          cnt_r  <= cnt_nxt_s;
          flag_r <= flag_nxt_s;
        end
      end

      assign value[gi*WIDTH +: WIDTH] = cnt_r;
      assign event_flag[gi]           = flag_r;
    end
  endgenerate

endmodule

// File: tb/tb_updown_counter_bank.sv
module tb_updown_counter_bank;

  logic        clock;
  logic        reset_;
  logic [3:0]  en;
  logic [3:0]  up;
  logic [3:0]  load;
  logic [63:0] load_value;
  logic [63:0] value;
  logic [3:0]  event_flag;
  logic        tick;
  logic        half_clock;

  int checks = 0;
  int errors = 0;

  updown_counter_bank dut (
    .clock      (clock),
    .reset_     (reset_),
    .en         (en),
    .up         (up),
    .load       (load),
    .load_value (load_value),
    .value      (value),
    .event_flag (event_flag),
    .tick       (tick),
    .half_clock (half_clock)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] ch(input int i);
    return value[i*16 +: 16];
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Advance until the current cycle is a tick cycle (bounded).
  task automatic align_tick();
    int n = 0;
    while (tick !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    checks++;
    if (tick !== 1'b1) begin
      errors++;
      $display("FAIL align_tick: tick=%b required 1 within 8 cycles", tick);
    end
  endtask

  task automatic test_reset();
    reset_ = 1'b0;
    en = 4'b0000; up = 4'b0000; load = 4'b0000; load_value = 64'h0;
    repeat (3) step();
    checks++;
    if (value !== 64'h0) begin errors++; $display("FAIL reset_value: got %h required 0", value); end
    checks++;
    if (event_flag !== 4'b0000) begin errors++; $display("FAIL reset_flag: got %b required 0000", event_flag); end
    checks++;
    if (half_clock !== 1'b0) begin errors++; $display("FAIL reset_half: got %b required 0", half_clock); end
    reset_ = 1'b1;
    checks++;
    if (tick !== 1'b0) begin errors++; $display("FAIL first_cycle_tick: got %b required 0", tick); end
    step();
    checks++;
    if (tick !== 1'b1) begin errors++; $display("FAIL second_cycle_tick: got %b required 1", tick); end
    step();
    checks++;
    if (half_clock !== 1'b1) begin errors++; $display("FAIL half_after_tick: got %b required 1", half_clock); end
  endtask

  task automatic test_count();
    int toggles = 0;
    logic prev;
    prev = half_clock;
    en = 4'b0001; up = 4'b0001;
    for (int k = 0; k < 20; k++) begin
      step();
      if (half_clock !== prev) toggles++;
      prev = half_clock;
    end
    en = 4'b0000;
    checks++;
    if (ch(0) !== 16'd10) begin errors++; $display("FAIL count_ch0: got %h required 000a", ch(0)); end
    checks++;
    if (value[63:16] !== 48'h0) begin errors++; $display("FAIL count_idle_ch: got %h required 0", value[63:16]); end
    checks++;
    if (toggles !== 10) begin errors++; $display("FAIL count_half_toggles: got %0d required 10", toggles); end
  endtask

  task automatic test_wrap();
    // up across max
    load = 4'b0010; load_value[31:16] = 16'hFFFF;
    step();
    load = 4'b0000;
    checks++;
    if (ch(1) !== 16'hFFFF) begin errors++; $display("FAIL load_ch1: got %h required ffff", ch(1)); end
    align_tick();
    up[1] = 1'b1; en[1] = 1'b1;
    step();
    en = 4'b0000;
`ifdef UPDOWN_COUNTER_BANK_SATURATE_EN
    checks++;
    if (ch(1) !== 16'hFFFF) begin errors++; $display("FAIL sat_up_ch1: got %h required ffff", ch(1)); end
`else
    checks++;
    if (ch(1) !== 16'h0000) begin errors++; $display("FAIL wrap_up_ch1: got %h required 0000", ch(1)); end
`endif
    checks++;
    if (event_flag !== 4'b0010) begin errors++; $display("FAIL wrap_up_flag: got %b required 0010", event_flag); end
    step();
    checks++;
    if (event_flag !== 4'b0000) begin errors++; $display("FAIL wrap_up_flag_clear: got %b required 0000", event_flag); end
    checks++;
    if (ch(0) !== 16'd10) begin errors++; $display("FAIL wrap_ch0_hold: got %h required 000a", ch(0)); end
    // down across zero
    load = 4'b0010; load_value[31:16] = 16'h0000;
    step();
    load = 4'b0000;
    align_tick();
    up[1] = 1'b0; en[1] = 1'b1;
    step();
    en = 4'b0000;
`ifdef UPDOWN_COUNTER_BANK_SATURATE_EN
    checks++;
    if (ch(1) !== 16'h0000) begin errors++; $display("FAIL sat_down_ch1: got %h required 0000", ch(1)); end
`else
    checks++;
    if (ch(1) !== 16'hFFFF) begin errors++; $display("FAIL wrap_down_ch1: got %h required ffff", ch(1)); end
`endif
    checks++;
    if (event_flag !== 4'b0010) begin errors++; $display("FAIL wrap_down_flag: got %b required 0010", event_flag); end
    step();
    checks++;
    if (event_flag !== 4'b0000) begin errors++; $display("FAIL wrap_down_flag_clear: got %b required 0000", event_flag); end
  endtask

  task automatic test_limit();
    int pulses = 0;
    load = 4'b0100; load_value[47:32] = 16'hFFFF;
    step();
    load = 4'b0000;
    align_tick();
    up[2] = 1'b1; en[2] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      if (event_flag[2] === 1'b1) pulses++;
    end
    en = 4'b0000;
`ifdef UPDOWN_COUNTER_BANK_SATURATE_EN
    checks++;
    if (ch(2) !== 16'hFFFF) begin errors++; $display("FAIL limit_up_value: got %h required ffff", ch(2)); end
    checks++;
    if (pulses !== 3) begin errors++; $display("FAIL limit_up_pulses: got %0d required 3", pulses); end
`else
    checks++;
    if (ch(2) !== 16'h0002) begin errors++; $display("FAIL limit_up_value: got %h required 0002", ch(2)); end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL limit_up_pulses: got %0d required 1", pulses); end
`endif
    // down from 1: first tick reaches 0 cleanly, second crosses
    load = 4'b0100; load_value[47:32] = 16'h0001;
    step();
    load = 4'b0000;
    align_tick();
    up[2] = 1'b0; en[2] = 1'b1;
    step();
    checks++;
    if (ch(2) !== 16'h0000 || event_flag[2] !== 1'b0) begin
      errors++; $display("FAIL limit_down_first: got %h flag %b required 0000 flag 0", ch(2), event_flag[2]);
    end
    step();
    step();
    en = 4'b0000;
`ifdef UPDOWN_COUNTER_BANK_SATURATE_EN
    checks++;
    if (ch(2) !== 16'h0000) begin errors++; $display("FAIL limit_down_second: got %h required 0000", ch(2)); end
`else
    checks++;
    if (ch(2) !== 16'hFFFF) begin errors++; $display("FAIL limit_down_second: got %h required ffff", ch(2)); end
`endif
    checks++;
    if (event_flag[2] !== 1'b1) begin errors++; $display("FAIL limit_down_flag: got %b required 1", event_flag[2]); end
  endtask

  task automatic test_priority();
    align_tick();
    load = 4'b1000; load_value[63:48] = 16'h1234; en[3] = 1'b1; up[3] = 1'b1;
    step();
    load = 4'b0000; en = 4'b0000;
    checks++;
    if (ch(3) !== 16'h1234) begin errors++; $display("FAIL priority_value: got %h required 1234", ch(3)); end
    checks++;
    if (event_flag[3] !== 1'b0) begin errors++; $display("FAIL priority_flag: got %b required 0", event_flag[3]); end
    step();
    checks++;
    if (ch(3) !== 16'h1234) begin errors++; $display("FAIL priority_hold: got %h required 1234", ch(3)); end
  endtask

  task automatic test_async_reset();
    en = 4'b0001; up = 4'b0001;
    repeat (3) step();
    #2;
    reset_ = 1'b0;
    #1;
    checks++;
    if (value !== 64'h0) begin errors++; $display("FAIL async_value: got %h required 0", value); end
    checks++;
    if (half_clock !== 1'b0 || event_flag !== 4'b0000) begin
      errors++; $display("FAIL async_misc: half %b flag %b required 0 0000", half_clock, event_flag);
    end
    #1;
    reset_ = 1'b1;
    repeat (4) step();
    en = 4'b0000;
    checks++;
    if (ch(0) !== 16'd2) begin errors++; $display("FAIL async_resume: got %h required 0002", ch(0)); end
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_limit();
    test_priority();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
